// File: rtl/hex_ctrl.sv
// Two-requester arbiter that writes 16-bit words to a 4-digit hex display, one nibble per cycle, with periodic redraw.
// Latency: ack 1 cycle after req, digits follow over 4 cycles; requests wait (no ack) while a word is being written.
module hex_ctrl #(
  parameter int REFRESH_DIV = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_req,
  input  logic [15:0] a_data,
  output logic        a_ack,
  input  logic        b_req,
  input  logic [15:0] b_data,
  output logic        b_ack,
  output logic        busy,
  output logic        hex_en,
  output logic [1:0]  hex_dig,
  output logic [3:0]  hex_val,
  output logic        owner
);

  typedef enum logic {IDLE, WRITE} state_t;

  localparam logic [15:0] REFRESH_MAX = 16'(REFRESH_DIV - 1);

  state_t      state_q, state_d;
  logic        go_q, go_d;
  logic        a_ack_q, a_ack_d;
  logic        b_ack_q, b_ack_d;
  logic        hex_en_q, hex_en_d;
  logic [1:0]  hex_dig_q, hex_dig_d;
  logic [3:0]  hex_val_q, hex_val_d;
  logic [15:0] shadow_q, shadow_d;
  logic        owner_q, owner_d;
  logic [15:0] refresh_q, refresh_d;
  logic        grant;
  logic        pick_b;

  function automatic logic [3:0] nib(input logic [15:0] w, input logic [1:0] i);
    nib = w[{i, 2'b00} +: 4];
  endfunction

  // Round-robin: on a tie the requester that does not currently own the display wins.
  assign pick_b = b_req && (!a_req || !owner_q);

  always_comb begin
    state_d   = state_q;
    go_d      = 1'b0;
    a_ack_d   = 1'b0;
    b_ack_d   = 1'b0;
    hex_en_d  = hex_en_q;
    hex_dig_d = hex_dig_q;
    hex_val_d = hex_val_q;
    shadow_d  = shadow_q;
    owner_d   = owner_q;
    refresh_d = refresh_q;
    grant     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (go_q) begin
          // Ack cycle: the requester still holds its data, capture it now.
          shadow_d  = owner_q ? b_data : a_data;
          state_d   = WRITE;
          hex_en_d  = 1'b1;
          hex_dig_d = 2'd0;
          hex_val_d = shadow_d[3:0];
          refresh_d = '0;
        end else if (a_req || b_req) begin
          grant = 1'b1;
        end else if (refresh_q == REFRESH_MAX) begin
          state_d   = WRITE;
          hex_en_d  = 1'b1;
          hex_dig_d = 2'd0;
          hex_val_d = shadow_q[3:0];
          refresh_d = '0;
        end else begin
          refresh_d = refresh_q + 16'd1;
        end
      end
      WRITE: begin
        if (hex_dig_q == 2'd3) begin
          // Arbitrate while the last digit is out so the next ack follows without a gap.
          state_d   = IDLE;
          hex_en_d  = 1'b0;
          refresh_d = '0;
          grant     = a_req || b_req;
        end else begin
          hex_dig_d = hex_dig_q + 2'd1;
          hex_val_d = nib(shadow_q, hex_dig_q + 2'd1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (grant) begin
      go_d      = 1'b1;
      a_ack_d   = !pick_b;
      b_ack_d   = pick_b;
      owner_d   = pick_b;
      refresh_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      go_q      <= 1'b0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      hex_en_q  <= 1'b0;
      hex_dig_q <= 2'd0;
      hex_val_q <= 4'd0;
      shadow_q  <= 16'h0000;
      owner_q   <= 1'b1;
      refresh_q <= '0;
    end else begin
      state_q   <= state_d;
      go_q      <= go_d;
      a_ack_q   <= a_ack_d;
      b_ack_q   <= b_ack_d;
      hex_en_q  <= hex_en_d;
      hex_dig_q <= hex_dig_d;
      hex_val_q <= hex_val_d;
      shadow_q  <= shadow_d;
      owner_q   <= owner_d;
      refresh_q <= refresh_d;
    end
  end

  assign a_ack   = a_ack_q;
  assign b_ack   = b_ack_q;
  assign busy    = hex_en_q;
  assign hex_en  = hex_en_q;
  assign hex_dig = hex_dig_q;
  assign hex_val = hex_val_q;
  assign owner   = owner_q;

endmodule

// File: tb/tb_hex_ctrl.sv
// Bench for hex_ctrl: expected digit writes are queued when requests are driven and popped by a monitor.
module tb_hex_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_req = 1'b0, b_req = 1'b0;
  logic [15:0] a_data = '0, b_data = '0;
  logic        a_ack, b_ack, busy, hex_en, owner;
  logic [1:0]  hex_dig;
  logic [3:0]  hex_val;

  typedef struct packed {
    logic [1:0] dig;
    logic [3:0] val;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  logic mon_en = 1'b0;

  hex_ctrl #(.REFRESH_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_data(a_data), .a_ack(a_ack),
    .b_req(b_req), .b_data(b_data), .b_ack(b_ack),
    .busy(busy), .hex_en(hex_en), .hex_dig(hex_dig), .hex_val(hex_val),
    .owner(owner)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every hex_en cycle must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if (a_ack || b_ack) begin
        checks++;
        if ((a_ack && b_ack) || hex_en) begin
          errors++;
          $display("FAIL ack_exclusive: a_ack=%0b b_ack=%0b hex_en=%0b, want one ack and hex_en=0", a_ack, b_ack, hex_en);
        end
      end
      if (busy !== hex_en) begin
        checks++;
        errors++;
        $display("FAIL busy_vs_en: busy=%0b hex_en=%0b, want equal", busy, hex_en);
      end
      if (hex_en) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: dig=%0d val=%h, want no write", hex_dig, hex_val);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          if ({hex_dig, hex_val} !== {e.dig, e.val}) begin
            errors++;
            $display("FAIL digit_write: got (%0d,%h), want (%0d,%h)", hex_dig, hex_val, e.dig, e.val);
          end
        end
      end
    end
  end

  task automatic push_word(input logic [15:0] w);
    wr_t e;
    for (int i = 0; i < 4; i++) begin
      e.dig = 2'(i);
      e.val = w[i*4 +: 4];
      exp_q.push_back(e);
    end
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic test_reset();
    a_req = 1'b0; b_req = 1'b0;
    rst_n = 1'b0;
    #23;
    checks++;
    if ({a_ack, b_ack, busy, hex_en, hex_dig, hex_val, owner} !== 11'b0000_00_0000_1) begin
      errors++;
      $display("FAIL reset_outputs: got ack=%0b%0b busy=%0b en=%0b dig=%0d val=%h owner=%0b, want 0 0 0 0 0 0 1",
               a_ack, b_ack, busy, hex_en, hex_dig, hex_val, owner);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    push_word(16'h0000);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL reset_shadow_replay: %0d writes missing, want 0", exp_q.size());
    end
    mon_en = 1'b0;
  endtask

  task automatic test_single_a();
    int got, busy_cnt;
    do_reset();
    push_word(16'h1A2F);
    a_data = 16'h1A2F; a_req = 1'b1;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (a_ack) got = 1;
    end
    checks++;
    if (!got || owner !== 1'b0 || b_ack !== 1'b0) begin
      errors++;
      $display("FAIL single_ack: ack_seen=%0d owner=%0b b_ack=%0b, want 1 0 0", got, owner, b_ack);
    end
    a_req = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (i == 0) begin
        checks++;
        if (a_ack !== 1'b0 || hex_en !== 1'b1) begin
          errors++;
          $display("FAIL single_pulse: a_ack=%0b hex_en=%0b after ack, want 0 1", a_ack, hex_en);
        end
      end
    end
    checks++;
    if (busy_cnt != 4 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL single_busy: busy cycles=%0d pending=%0d, want 4 0", busy_cnt, exp_q.size());
    end
    mon_en = 1'b0;
  endtask

  task automatic test_round_robin();
    int n;
    int at[3];
    logic who[3];
    a_data = 16'h1111; b_data = 16'h2222;
    a_req = 1'b1; b_req = 1'b1;
    do_reset();
    push_word(16'h1111); push_word(16'h2222); push_word(16'h1111);
    n = 0;
    for (int i = 0; i < 30 && n < 3; i++) begin
      @(negedge clk);
      if (a_ack || b_ack) begin
        who[n] = b_ack;
        at[n] = i;
        n++;
      end
    end
    a_req = 1'b0; b_req = 1'b0;
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL rr_count: acks=%0d, want 3", n);
    end else begin
      checks++;
      if (who[0] !== 1'b0 || at[0] != 0) begin
        errors++;
        $display("FAIL rr_first: who=%0b at=%0d, want A at 0", who[0], at[0]);
      end
      checks++;
      if (who[1] !== 1'b1 || at[1] - at[0] != 5) begin
        errors++;
        $display("FAIL rr_second: who=%0b gap=%0d, want B gap 5", who[1], at[1] - at[0]);
      end
      checks++;
      if (who[2] !== 1'b0 || at[2] - at[1] != 5) begin
        errors++;
        $display("FAIL rr_third: who=%0b gap=%0d, want A gap 5", who[2], at[2] - at[1]);
      end
    end
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rr_writes: %0d writes missing, want 0", exp_q.size());
    end
    mon_en = 1'b0;
  endtask

  task automatic test_refresh();
    int got, extra, ownbad;
    int starts[$];
    do_reset();
    push_word(16'hBEEF); push_word(16'hBEEF); push_word(16'hBEEF);
    b_data = 16'hBEEF; b_req = 1'b1;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (b_ack) got = 1;
    end
    b_req = 1'b0;
    extra = 0; ownbad = 0;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      if (a_ack || b_ack) extra++;
      if (owner !== 1'b1) ownbad++;
      if (hex_en && hex_dig == 2'd0) starts.push_back(i);
    end
    mon_en = 1'b0;
    checks++;
    if (!got || extra != 0 || ownbad != 0) begin
      errors++;
      $display("FAIL refresh_acks: b_ack_seen=%0d extra_acks=%0d owner_bad=%0d, want 1 0 0", got, extra, ownbad);
    end
    checks++;
    if (starts.size() != 3) begin
      errors++;
      $display("FAIL refresh_count: word starts=%0d, want 3", starts.size());
    end else if (starts[0] != 1 || starts[1] - starts[0] != 8 || starts[2] - starts[1] != 8) begin
      errors++;
      $display("FAIL refresh_period: starts=%0d,%0d,%0d, want 1,9,17", starts[0], starts[1], starts[2]);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL refresh_writes: %0d writes missing, want 0", exp_q.size());
    end
  endtask

  task automatic test_refresh_race();
    do_reset();
    repeat (3) @(negedge clk);
    push_word(16'h0005);
    a_data = 16'h0005; a_req = 1'b1;
    @(negedge clk);
    checks++;
    if (a_ack !== 1'b1 || hex_en !== 1'b0) begin
      errors++;
      $display("FAIL race_ack: a_ack=%0b hex_en=%0b, want 1 0", a_ack, hex_en);
    end
    a_req = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL race_writes: %0d writes missing, want 0", exp_q.size());
    end
    mon_en = 1'b0;
  endtask

  task automatic test_reset_mid_write();
    int got, en_bad;
    wr_t e;
    do_reset();
    e.dig = 2'd0; e.val = 4'h1; exp_q.push_back(e);
    e.dig = 2'd1; e.val = 4'h2; exp_q.push_back(e);
    a_data = 16'h4321; a_req = 1'b1;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (a_ack) got = 1;
    end
    a_req = 1'b0;
    b_data = 16'h9876; b_req = 1'b1;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (hex_en && hex_dig == 2'd1) got = 1;
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (!got || hex_en !== 1'b0 || hex_dig !== 2'd0 || busy !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL abort_reset: dig1_seen=%0d hex_en=%0b dig=%0d busy=%0b pending=%0d, want 1 0 0 0 0",
               got, hex_en, hex_dig, busy, exp_q.size());
    end
    en_bad = 0;
    repeat (2) begin
      @(negedge clk);
      if (hex_en) en_bad++;
    end
    checks++;
    if (en_bad != 0) begin
      errors++;
      $display("FAIL abort_quiet: hex_en cycles in reset=%0d, want 0", en_bad);
    end
    rst_n = 1'b1;
    push_word(16'h9876);
    @(negedge clk);
    checks++;
    if (b_ack !== 1'b1 || owner !== 1'b1) begin
      errors++;
      $display("FAIL abort_reack: b_ack=%0b owner=%0b, want 1 1", b_ack, owner);
    end
    b_req = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL abort_writes: %0d writes missing, want 0", exp_q.size());
    end
    mon_en = 1'b0;
  endtask

  task automatic test_withdraw();
    int got, bad;
    do_reset();
    push_word(16'h0F0F);
    a_data = 16'h0F0F; a_req = 1'b1;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (a_ack) got = 1;
    end
    a_req = 1'b0;
    bad = 0;
    @(negedge clk);
    b_data = 16'h3333; b_req = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (b_ack) bad++;
    end
    b_req = 1'b0;
    @(negedge clk);
    if (b_ack) bad++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (b_ack || busy) bad++;
    end
    checks++;
    if (!got || bad != 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL withdraw: a_ack_seen=%0d bad_cycles=%0d pending=%0d, want 1 0 0", got, bad, exp_q.size());
    end
    mon_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_a();
    test_round_robin();
    test_refresh();
    test_refresh_race();
    test_reset_mid_write();
    test_withdraw();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
